// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizes for the serial pattern detection controller.
//   state_t   : controller FSM states (IDLE, RUN, DONE)
//   seq_cfg_t : configuration captured on cfg_load while idle
// The config struct is sized by the SEQ_* defaults below; instantiate the
// controller with parameters equal to these defaults.
package seq_ctrl_pkg;

  localparam int SEQ_PAT_W = 8;
  localparam int SEQ_CNT_W = 8;
  localparam int SEQ_TMO_W = 16;
  localparam int SEQ_LEN_W = $clog2(SEQ_PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEQ_PAT_W-1:0] pattern;
    logic [SEQ_LEN_W-1:0] len;
    logic                 overlap;
    logic [SEQ_CNT_W-1:0] target;
    logic [SEQ_TMO_W-1:0] tmo;
  } seq_cfg_t;

endpackage

// File: rtl/seq_match_core.sv
// Shift register, fill counter and length-masked compare for the detector.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : empty the shift register and fill counter (run entry)
//   shift_en  : accept bit_in this cycle
//   bit_in    : serial data bit
//   pattern   : reference pattern, bit len-1 is the oldest bit
//   len       : active length (already clamped to PAT_W); 0 never matches
//   overlap   : 0 = restart filling after every match
//   match     : registered, high the cycle after the completing bit
module seq_match_core
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match
);

  logic [PAT_W-1:0] sr_q, sr_d, sr_shift, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
  logic             match_q, match_d, hit;

  // Only the newest len bits take part in the compare.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign mask[gi] = (LEN_W'(gi) < len);
  end

  assign sr_shift = {sr_q[PAT_W-2:0], bit_in};
  assign fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
  // Evaluated on the post-shift contents so the completing bit counts.
  assign hit = (len != '0) && (fill_inc >= len) &&
               (((sr_shift ^ pattern) & mask) == '0);

  always_comb begin
    sr_d    = sr_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (shift_en) begin
      sr_d    = sr_shift;
      // Non-overlap: stale bits stay in sr but are ignored until refilled.
      fill_d  = (hit && !overlap) ? '0 : fill_inc;
      match_d = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detection controller.
// Loads a pattern while idle, counts matches during a run armed by start,
// and reports completion (target reached or timeout) via valid/ready.
//   cfg_*        : configuration, captured on cfg_load in IDLE only
//   start/abort  : arm a run (IDLE) / cancel a run (RUN)
//   in_bit/valid : qualified serial stream
//   match_pulse  : one pulse per detected match
//   busy         : high while running
//   evt_valid/ready, evt_count, evt_timeout : completion event
// Optional feature macro: SEQ_TIMEOUT_EN adds a no-match timeout counter;
// without it evt_timeout is constant 0 and cfg_tmo is unused.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = SEQ_CNT_W,
  parameter int TMO_W = SEQ_TMO_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic [CNT_W-1:0]           cfg_target,
  input  logic [TMO_W-1:0]           cfg_tmo,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_bit,
  input  logic                       in_valid,
  output logic                       match_pulse,
  output logic                       busy,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [CNT_W-1:0]           evt_count,
  output logic                       evt_timeout
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  state_t           state_q, state_d;
  seq_cfg_t         cfg_q, cfg_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             tmo_flag_q, tmo_flag_d;
  logic             core_match, start_run, final_match, timeout_hit, shift_en;
  logic [LEN_W-1:0] len_clamped;

  assign start_run   = (state_q == IDLE) && start;
  assign count_inc   = (count_q == '1) ? count_q : count_q + CNT_W'(1);
  assign final_match = core_match && (cfg_q.target != '0) &&
                       (count_inc == cfg_q.target);
  assign len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

`ifdef SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;

  assign tmo_inc = tmo_cnt_q + TMO_W'(1);
  // A match restarts the window, so a match cycle never times out.
  assign timeout_hit = (state_q == RUN) && !core_match &&
                       (cfg_q.tmo != '0) && (tmo_inc == cfg_q.tmo);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (start_run)             tmo_cnt_d = '0;
    else if (state_q == RUN)   tmo_cnt_d = core_match ? '0 : tmo_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^cfg_q.tmo;
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: abort beats a final match, a final match beats a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)            state_d = IDLE;
        else if (final_match) state_d = DONE;
        else if (timeout_hit) state_d = DONE;
      end
      DONE:    if (evt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy        = (state_q == RUN);
    evt_valid   = (state_q == DONE);
    evt_count   = count_q;
    evt_timeout = tmo_flag_q;
    match_pulse = core_match;
  end

  // Config capture, match count and timeout flag.
  always_comb begin
    cfg_d      = cfg_q;
    count_d    = count_q;
    tmo_flag_d = tmo_flag_q;
    if ((state_q == IDLE) && cfg_load) begin
      cfg_d.pattern = cfg_pattern;
      cfg_d.len     = len_clamped;
      cfg_d.overlap = cfg_overlap;
      cfg_d.target  = cfg_target;
      cfg_d.tmo     = cfg_tmo;
    end
    if (start_run) begin
      count_d    = '0;
      tmo_flag_d = 1'b0;
    end else if (state_q == RUN) begin
      if (core_match) count_d = count_inc;
      if (!abort && !final_match && timeout_hit) tmo_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '{pattern: '0, len: '0, overlap: 1'b1, target: '0, tmo: '0};
      count_q    <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      count_q    <= count_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Bits are only consumed while the run continues past this cycle, so no
  // stray match pulse can appear after leaving RUN.
  assign shift_en = (state_q == RUN) && in_valid && (state_d == RUN);

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_run),
    .shift_en (shift_en),
    .bit_in   (in_bit),
    .pattern  (cfg_q.pattern),
    .len      (cfg_q.len),
    .overlap  (cfg_q.overlap),
    .match    (core_match)
  );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int TMO_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [3:0]       cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic [TMO_W-1:0] cfg_tmo = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic             evt_ready = 1'b0;
  logic             match_pulse, busy, evt_valid, evt_timeout;
  logic [CNT_W-1:0] evt_count;
  logic [11:0]      dut_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .cfg_tmo(cfg_tmo), .start(start), .abort(abort), .in_bit(in_bit),
    .in_valid(in_valid), .match_pulse(match_pulse), .busy(busy),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_count(evt_count),
    .evt_timeout(evt_timeout)
  );

  assign dut_vec = {match_pulse, busy, evt_valid, evt_count, evt_timeout};

  // ---------------- behavioural reference model ----------------
  // Keeps the received bits as a history queue and compares its tail with
  // the pattern; tracks run/done, match count and a no-match cycle count.
  bit         m_run, m_done, m_pulse, m_tflag, m_ovl;
  int         m_count, m_tcnt, m_len, m_target, m_tmo;
  bit [7:0]   m_pat;
  bit         m_hist[$];

  function automatic logic [11:0] model_vec();
    return {m_pulse, m_run, m_done, m_count[7:0], m_tflag};
  endfunction

  function automatic void model_step();
    int  nc;
    bit  fin, tmo_hit, stay, np;
    if (rst) begin
      m_run = 0; m_done = 0; m_pulse = 0; m_tflag = 0; m_count = 0; m_tcnt = 0;
      m_pat = 0; m_len = 0; m_ovl = 1; m_target = 0; m_tmo = 0;
      m_hist.delete();
      return;
    end
    if (!m_run && !m_done) begin
      if (cfg_load) begin
        m_pat = cfg_pattern; m_len = (int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
        m_ovl = cfg_overlap; m_target = int'(cfg_target); m_tmo = int'(cfg_tmo);
      end
      m_pulse = 0;
      if (start) begin
        m_run = 1; m_hist.delete(); m_count = 0; m_tcnt = 0; m_tflag = 0;
      end
    end else if (m_run) begin
      nc  = m_pulse ? ((m_count == 255) ? 255 : m_count + 1) : m_count;
      fin = m_pulse && (m_target != 0) && (nc == m_target);
      tmo_hit = !m_pulse && (m_tmo != 0) && (m_tcnt + 1 == m_tmo);
`ifndef SEQ_TIMEOUT_EN
      tmo_hit = 0;
`endif
      m_tcnt  = m_pulse ? 0 : m_tcnt + 1;
      m_count = nc;
      stay = !abort && !fin && !tmo_hit;
      np = 0;
      if (stay && in_valid) begin
        m_hist.push_back(in_bit);
        if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
        if (m_len != 0 && m_hist.size() >= m_len) begin
          np = 1;
          for (int i = 0; i < m_len; i++)
            if (m_hist[m_hist.size() - m_len + i] != m_pat[m_len - 1 - i]) np = 0;
          if (np && !m_ovl) m_hist.delete();
        end
      end
      m_pulse = np;
      if (!stay) begin
        m_run = 0;
        if (!abort) begin m_done = 1; m_tflag = !fin; end
      end
    end else begin
      m_pulse = 0;
      if (evt_ready) m_done = 0;
    end
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start = 0; abort = 0; cfg_load = 0; in_valid = 0; in_bit = 0; evt_ready = 0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic [7:0] tgt, input logic [15:0] tmo);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt; cfg_tmo = tmo;
    cfg_load = 1; step(); cfg_load = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle(); rst = 1; step(); step();
    checks++;
    if (dut_vec !== 12'h000) begin
      errors++; $display("FAIL reset_outputs got=%h want=000", dut_vec);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_model got=%h want=%h", dut_vec, model_vec());
    end
    rst = 0;
    $display("test_reset done");
  endtask

  task automatic test_overlap();
    logic [4:0] seq = 5'b10101;
    logic [4:0] seen = '0;
    drive_idle(); load_cfg(8'b101, 4'd3, 1'b1, 8'd2, 16'd0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_bit = seq[4-i]; step();
      seen[i] = match_pulse;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL overlap_bit%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    in_valid = 0; step();
    checks++;
    if (seen !== 5'b10100) begin
      errors++; $display("FAIL overlap_pulses got=%b want=10100", seen);
    end
    checks++;
    if ({busy, evt_valid, evt_count, evt_timeout} !== {1'b0, 1'b1, 8'd2, 1'b0}) begin
      errors++; $display("FAIL overlap_done got busy=%b valid=%b count=%0d want 0/1/2",
                         busy, evt_valid, evt_count);
    end
    evt_ready = 1; step(); evt_ready = 0;
    checks++;
    if ({busy, evt_valid} !== 2'b00) begin
      errors++; $display("FAIL overlap_release got=%b%b want=00", busy, evt_valid);
    end
    $display("test_overlap done");
  endtask

  task automatic test_nonoverlap();
    logic [6:0] seq = 7'b1010101;
    logic [6:0] seen = '0;
    drive_idle(); load_cfg(8'b101, 4'd3, 1'b0, 8'd2, 16'd0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_bit = seq[6-i]; step();
      seen[i] = match_pulse;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL nonoverlap_bit%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    in_valid = 0; step();
    checks++;
    if (seen !== 7'b1000100) begin
      errors++; $display("FAIL nonoverlap_pulses got=%b want=1000100", seen);
    end
    checks++;
    if ({evt_valid, evt_count} !== {1'b1, 8'd2}) begin
      errors++; $display("FAIL nonoverlap_done got valid=%b count=%0d want 1/2", evt_valid, evt_count);
    end
    evt_ready = 1; step(); evt_ready = 0;
    $display("test_nonoverlap done");
  endtask

  task automatic test_done_hold();
    logic [6:0] seq = 7'b1010101;
    drive_idle(); load_cfg(8'b101, 4'd3, 1'b1, 8'd3, 16'd0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_bit = seq[6-i]; step();
    end
    in_valid = 0; step();
    for (int k = 0; k < 5; k++) begin
      // start/abort/cfg_load must all be ignored while the event is pending
      start = 1; abort = 1; cfg_load = 1; cfg_pattern = 8'hFF; cfg_len = 4'd1;
      step();
      checks++;
      if ({busy, evt_valid, evt_count, evt_timeout} !== {1'b0, 1'b1, 8'd3, 1'b0}) begin
        errors++; $display("FAIL hold_cycle%0d got valid=%b count=%0d want 1/3", k, evt_valid, evt_count);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL hold_model%0d got=%h want=%h", k, dut_vec, model_vec());
      end
    end
    drive_idle(); evt_ready = 1; step(); evt_ready = 0;
    checks++;
    if ({busy, evt_valid} !== 2'b00) begin
      errors++; $display("FAIL hold_release got=%b%b want=00", busy, evt_valid);
    end
    $display("test_done_hold done");
  endtask

  task automatic test_abort_final();
    logic [4:0] seq = 5'b10101;
    drive_idle(); load_cfg(8'b101, 4'd3, 1'b1, 8'd2, 16'd0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_bit = seq[4-i]; step();
    end
    checks++;
    if (match_pulse !== 1'b1) begin
      errors++; $display("FAIL abort_final_pulse got=%b want=1", match_pulse);
    end
    in_valid = 0; abort = 1; step(); abort = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({busy, evt_valid} !== 2'b00) begin
        errors++; $display("FAIL abort_idle%0d got=%b%b want=00", k, busy, evt_valid);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL abort_model%0d got=%h want=%h", k, dut_vec, model_vec());
      end
      step();
    end
    start = 1; step(); start = 0;
    checks++;
    if ({busy, evt_count} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL abort_restart got busy=%b count=%0d want 1/0", busy, evt_count);
    end
    abort = 1; step(); abort = 0;
    $display("test_abort_final done");
  endtask

  task automatic test_cfg_clamp_gaps();
    logic [7:0] pat = 8'hCA;
    int gaps;
    drive_idle(); load_cfg(pat, 4'd12, 1'b1, 8'd1, 16'd0);
    start = 1; step(); start = 0;
    // reload attempt while running: would match "11" immediately if honoured
    cfg_pattern = 8'hFF; cfg_len = 4'd2; cfg_load = 1; step(); cfg_load = 0;
    for (int i = 0; i < 8; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 0; in_bit = 1'($urandom); step();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL gap_model%0d got=%h want=%h", i, dut_vec, model_vec());
        end
      end
      in_valid = 1; in_bit = pat[7-i]; step();
      checks++;
      if (match_pulse !== (i == 7)) begin
        errors++; $display("FAIL clamp_bit%0d got=%b want=%b", i, match_pulse, (i == 7));
      end
    end
    in_valid = 0; step();
    checks++;
    if ({evt_valid, evt_count} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL clamp_done got valid=%b count=%0d want 1/1", evt_valid, evt_count);
    end
    evt_ready = 1; step(); evt_ready = 0;
    $display("test_cfg_clamp_gaps done");
  endtask

  task automatic test_timeout();
    drive_idle(); load_cfg(8'b101, 4'd3, 1'b1, 8'd1, 16'd10);
    start = 1; step(); start = 0;
`ifdef SEQ_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1; in_bit = 0; step();
      checks++;
      if (k < 10 && {busy, evt_valid} !== 2'b10) begin
        errors++; $display("FAIL timeout_early%0d got=%b%b want=10", k, busy, evt_valid);
      end
      if (k == 10 && {busy, evt_valid, evt_count, evt_timeout} !== {1'b0, 1'b1, 8'd0, 1'b1}) begin
        errors++; $display("FAIL timeout_done got valid=%b tmo=%b count=%0d want 1/1/0",
                           evt_valid, evt_timeout, evt_count);
      end
    end
    in_valid = 0; evt_ready = 1; step(); evt_ready = 0;
`else
    for (int k = 1; k <= 15; k++) begin
      in_valid = 1; in_bit = 0; step();
      checks++;
      if ({busy, evt_valid, evt_timeout} !== 3'b100) begin
        errors++; $display("FAIL notimeout%0d got=%b%b%b want=100", k, busy, evt_valid, evt_timeout);
      end
    end
    in_valid = 0; abort = 1; step(); abort = 0;
`endif
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL timeout_model got=%h want=%h", dut_vec, model_vec());
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_run();
    logic [2:0] seq = 3'b101;
    drive_idle(); load_cfg(8'b101, 4'd3, 1'b1, 8'd0, 16'd0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_bit = seq[2-i]; step();
    end
    checks++;
    if ({match_pulse, busy} !== 2'b11) begin
      errors++; $display("FAIL midrun_pre got=%b%b want=11", match_pulse, busy);
    end
    rst = 1; step(); rst = 0; in_valid = 0;
    checks++;
    if (dut_vec !== 12'h000) begin
      errors++; $display("FAIL midrun_reset got=%h want=000", dut_vec);
    end
    $display("test_reset_mid_run done");
  endtask

  task automatic test_random();
    drive_idle();
    for (int c = 0; c < 3000; c++) begin
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 10));
      cfg_overlap = 1'($urandom);
      cfg_target  = 8'($urandom_range(0, 5));
      cfg_tmo     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(3, 40));
      cfg_load    = ($urandom_range(0, 29) == 0);
      start       = ($urandom_range(0, 9) == 0);
      abort       = ($urandom_range(0, 99) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_bit      = 1'($urandom);
      evt_ready   = ($urandom_range(0, 2) == 0);
      if (evt_valid && evt_ready)
        $display("event accepted count=%0d timeout=%0d", evt_count, evt_timeout);
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL random_cycle%0d got=%h want=%h", c, dut_vec, model_vec());
      end
    end
    drive_idle();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_done_hold();
    test_abort_final();
    test_cfg_clamp_gaps();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
